// File: rtl/hrm_pkg.sv
// Shared HRM datapath definitions: item width/type and register mux select codes.
package hrm_pkg;

    localparam int unsigned DATA_W = 8;

    typedef logic signed [DATA_W-1:0] data_t;

    // muxR select code that routes the inbox head into the register
    localparam logic [1:0] MUXR_INBOX = 2'b00;

endpackage

// File: rtl/inbox_if.sv
// Push/pop/status bundle between the inbox queue and its producer/consumer.
interface inbox_if
    import hrm_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned W     = DATA_W
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  iData;
    logic          wI;
    logic          rI;
    logic [W-1:0]  oData;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          ovf;
    logic          udf;

    // Producer/control side: drives push data and strobes, observes status
    modport master (
        output iData, wI, rI,
        input  oData, empty, full, count, ovf, udf
    );

    // Queue side
    modport slave (
        input  iData, wI, rI,
        output oData, empty, full, count, ovf, udf
    );

endinterface

// File: rtl/inbox_fifo_ctrl.sv
// Pointer, occupancy and sticky error-flag logic for a power-of-two FIFO.
module fifo_ctrl #(
    parameter int unsigned DEPTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    output logic          push_acc_o,
    output logic [AW-1:0] wp_o,
    output logic [AW-1:0] rp_o,
    output logic [CW-1:0] cnt_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          ovf_o,
    output logic          udf_o
);

    logic [AW-1:0] rp_q, rp_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          empty, full, push_acc, pop_acc;

    // Accept decisions and next-state; a pop frees a slot for a push when full,
    // but an empty queue never bypasses the incoming item to the pop.
    always_comb begin
        empty    = (cnt_q == '0);
        full     = (cnt_q == CW'(DEPTH));
        push_acc = push_i && (!full || pop_i);
        pop_acc  = pop_i && !empty;
        wp_d     = wp_q + AW'(push_acc);
        rp_d     = rp_q + AW'(pop_acc);
        cnt_d    = cnt_q + CW'(push_acc) - CW'(pop_acc);
        ovf_d    = ovf_q | (push_i && !push_acc);
        udf_d    = udf_q | (pop_i && !pop_acc);
    end

    // State registers; reset overrides any push/pop in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rp_q  <= '0;
            wp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            rp_q  <= rp_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign push_acc_o = push_acc && !rst;
    assign wp_o       = wp_q;
    assign rp_o       = rp_q;
    assign cnt_o      = cnt_q;
    assign empty_o    = empty;
    assign full_o     = full;
    assign ovf_o      = ovf_q;
    assign udf_o      = udf_q;

endmodule

// File: rtl/inbox.sv
// HRM input queue: first-word fall-through FIFO feeding the register's iInbox.
module inbox
    import hrm_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned W     = DATA_W
) (
    input logic   clk,
    input logic   rst,
    inbox_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          push_acc, empty, full, ovf, udf;

    fifo_ctrl #(
        .DEPTH(DEPTH)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .push_i     (bus.wI),
        .pop_i      (bus.rI),
        .push_acc_o (push_acc),
        .wp_o       (wp),
        .rp_o       (rp),
        .cnt_o      (cnt),
        .empty_o    (empty),
        .full_o     (full),
        .ovf_o      (ovf),
        .udf_o      (udf)
    );

    // Storage write; contents are not reset, validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wp] <= bus.iData;
        end
    end

    assign bus.oData = empty ? '0 : mem_q[rp];
    assign bus.empty = empty;
    assign bus.full  = full;
    assign bus.count = cnt;
    assign bus.ovf   = ovf;
    assign bus.udf   = udf;

endmodule

// File: doc/inbox.md
# inbox

Input queue for the HRM CPU datapath; it sits directly upstream of `register`, whose `iInbox` input it drives. External stimulus (testbench loader or I/O) pushes signed 8-bit items in. The control unit pops one item per INBOX instruction, in the same cycle that `register` latches it through `muxR = 2'b00` and `wR`. The `empty` flag is the program-termination condition: INBOX on an empty queue ends the program.

## Interface
- `DEPTH`, default 32: number of entries; power of two, at least 2.
- `W`, default 8: item width; the item is interpreted as signed.
- `clk`  in  1: single clock; all state updates on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `iData`  in  W: item to push.
- `wI`  in  1: push strobe; one item per cycle while high.
- `rI`  in  1: pop strobe from the control unit.
- `oData`  out  W: head item, first-word fall-through.
- `empty`  out  1: queue holds 0 items.
- `full`  out  1: queue holds `DEPTH` items.
- `count`  out  $clog2(DEPTH)+1: current occupancy.
- `ovf`  out  1: sticky; a push was attempted while full.
- `udf`  out  1: sticky; a pop was attempted while empty.

## Operation
- Storage: `DEPTH` x `W` array, read pointer `rp`, write pointer `wp`, occupancy `cnt`.
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally from `DEPTH-1` to 0.
- Push accepted when `wI && (!full || rI)`: `mem[wp] <= iData`, then `wp++`.
- Pop accepted when `rI && !empty`: `rp++`.
- Occupancy update each cycle: `cnt <= cnt + push_acc - pop_acc`.
- Full with both `wI` and `rI` high:
  - both are accepted and `cnt` is unchanged;
  - `oData` shows the old head this cycle;
  - the new item goes into the slot just vacated.
- Empty with both `wI` and `rI` high:
  - the pop is rejected and `udf` is set;
  - the push is accepted and `cnt` goes to 1.
  - There is no bypass: the written item is not popped in the same cycle.
- Rejected push (full, no pop): item dropped, `ovf <= 1`, no state change.
- Rejected pop (empty): pointers unchanged, `udf <= 1`.
- `ovf` and `udf` clear only on `rst`.
- `oData = empty ? 0 : mem[rp]`, combinational from the registered `rp`.
- Status outputs are decoded from `cnt`: `empty = (cnt == 0)`, `full = (cnt == DEPTH)`.
- `count = cnt`.

## Timing
- Reset values: `rp = wp = cnt = 0`, so `empty = 1`, `full = 0`, `count = 0`, `oData = 0`, `ovf = udf = 0`. Memory contents are not reset.
- `rst` dominates: with `rst` high at an edge, `wI` and `rI` are ignored. Reset during operation discards every queued item.
- Push latency: an item pushed at edge N is visible on `oData` after edge N if the queue was empty; `empty` falls after edge N.
- Pop handshake with `register`:
  - the control unit asserts `rI` and `wR` in the same cycle;
  - `register` samples the current `oData` at edge N;
  - `oData` advances to the next item after edge N.
- Control must test `empty` before asserting `rI`. A pop on an empty queue is a protocol error and is flagged only, never stalled.
- No combinational path from `rI`/`wI` to any output. `oData`, `empty`, `full` and `count` depend only on registered state.

## Structure
- Shared package `hrm_pkg`:
  - `DATA_W = 8` and the typedef `data_t = logic signed [7:0]`, also used by `register`, ALU and outbox;
  - `MUXR_INBOX = 2'b00` (the `muxR` select code).
- One natural sub-module, `fifo_ctrl`: pointer/count/flag logic parameterised by `DEPTH`. `inbox` wraps it with the storage array and `oData` masking.
- `outbox` reuses `fifo_ctrl` unchanged.

## Test plan
- Reset then idle: `empty = 1`, `count = 0`, `oData = 0`, `ovf = udf = 0`; holds for 5 cycles.
- Push 3, -5, 127, then pop 3 times with `register` (`muxR = 00`, `wR = 1`):
  - R = 3, then -5 (`8'hFB`), then 127;
  - `count` reads 3, 2, 1, 0;
  - `empty = 1` after the last pop.
- Fill `DEPTH = 4` with 1, 2, 3, 4: `full = 1`.
  - Push 9 alone: dropped, `ovf = 1`, `count = 4`.
  - Then push 5 with pop: `oData` was 1; after the edge the queue holds 2, 3, 4, 5 and `count = 4`.
- Wrap-around at `DEPTH = 4`: run 10 push/pop pairs of values 0..9; the pop order is exactly 0..9 and `count` never exceeds 1.
- Pop on empty with a simultaneous push of 42:
  - `udf = 1` and `count = 1`;
  - `oData = 42` after the edge and R is unchanged by the pop.
- Push 7 and 8, then `rst` together with `wI = rI = 1`: after the edge `count = 0`, `empty = 1`, `oData = 0`, and both flags clear.
